reg_decode_scoreboard: RTL
==========================

# reg_decode_scoreboard

Parametrised register-file write decoder with a pending-write scoreboard, for the processor's register file.
- Decodes an ADDR_W-bit writeback address into a registered one-hot write-enable vector.
- Tracks which destination registers have in-flight writes, throttles issue to busy destinations, and flags read-after-write hazards for two source ports.
- Sits between the issue stage and the register file write port.

## Interface
Parameters:
- ADDR_W, 5, register address width; NREG = 2**ADDR_W registers.
- ZERO_REG, 1, when 1 register 0 is hard-wired: never busy, never write-enabled, never hazards.

Ports:
- clock  in  1  rising-edge clock, single clock domain.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  issue stage requests a destination reservation.
- issue_addr  in  ADDR_W  destination register being issued.
- issue_ready  out  1  reservation accepted this cycle (combinational).
- wb_valid  in  1  writeback data present this cycle.
- wb_addr  in  ADDR_W  writeback destination.
- we_onehot  out  NREG  registered one-hot write enable to the register file.
- wb_err  out  1  registered pulse: writeback to a register that was not busy.
- rs_addr_a, rs_addr_b  in  ADDR_W  source operand addresses.
- hazard_a, hazard_b  out  1  source register has a pending write (combinational).
- busy  out  NREG  scoreboard state, bit i = register i pending.
- pending_count  out  ADDR_W+1  number of set busy bits (registered).

## Operation
- Masked address: an address is masked when ZERO_REG=1 and the address equals 0.
- Issue:
  - issue_ready = !busy[issue_addr], or 1 when issue_addr is masked.
  - Fire = issue_valid && issue_ready.
  - On fire, busy[issue_addr] is set at the clock edge unless issue_addr is masked.
- Writeback:
  - On wb_valid, busy[wb_addr] is cleared at the clock edge.
  - we_onehot has bit wb_addr set in the next cycle; all other bits are 0.
  - For a masked wb_addr, we_onehot is all zero, busy is unchanged and wb_err stays 0.
- Error:
  - If wb_valid and wb_addr is unmasked and busy[wb_addr]=0 (registered state), wb_err=1 in the next cycle.
  - The write is still decoded into we_onehot.
- Simultaneous issue fire and writeback:
  - Different addresses: set and clear both apply.
  - Same address: only possible when that register is not busy. The issue wins, so busy ends at 1, and wb_err=1.
- Hazards:
  - hazard_x = busy[rs_addr_x] from registered state; 0 if rs_addr_x is masked.
  - There is no same-cycle writeback bypass: a register cleared at edge k reports no hazard from cycle k+1.
- pending_count:
  - Registered and updated at the same edge as busy; always equals popcount(busy).
  - Per cycle: +1 on an unmasked issue fire, -1 on an unmasked writeback to a busy register, net 0 when both happen.
  - Maximum value is NREG - ZERO_REG.
- we_onehot has at most one bit set in any cycle.

## Timing
- Reset (asynchronous, any cycle, including mid-operation):
  - busy=0, we_onehot=0, wb_err=0, pending_count=0 immediately.
  - issue_ready=1 and hazard_a/b=0 follow combinationally.
  - In-flight writebacks captured before reset are discarded.
- Latencies:
  - issue_ready and hazard_a/b: 0 cycles (combinational from inputs and registered busy).
  - busy set/clear: visible the cycle after the input edge.
  - we_onehot and wb_err: asserted exactly one cycle after wb_valid, for one cycle per wb_valid.
- Back-to-back:
  - A writeback every cycle produces a one-hot pulse every cycle.
  - A re-issue to the same register is accepted the cycle after its writeback edge.
- Full scoreboard: issue_ready=0 for every unmasked address. This is not a stall of the writeback path.

## Test plan
- Reset then idle:
  - Assert reset mid-cycle, release.
  - Required: busy=0, pending_count=0, we_onehot=0, issue_ready=1 for all addresses, hazard_a/b=0.
- Issue/writeback round trip:
  - Issue r5 at cycle 1.
  - Required: busy[5]=1, pending_count=1, hazard_a=1 for rs_addr_a=5, issue_ready=0 for issue_addr=5.
  - wb r5 at cycle 3.
  - Required: we_onehot=32'h0000_0020 at cycle 4, busy[5]=0, pending_count=0, wb_err=0.
- Decode sweep, ADDR_W=5 and ADDR_W=3:
  - wb every address 0..NREG-1 back-to-back, each pre-issued.
  - Required: we_onehot = 1<<addr one cycle later, zero for addr 0 with ZERO_REG=1, pending_count back to 0.
- Same-address collision:
  - r7 not busy; issue r7 and wb r7 in the same cycle.
  - Required: busy[7]=1, wb_err=1 next cycle, we_onehot bit 7 set, pending_count=1.
- Full scoreboard, ADDR_W=3, ZERO_REG=1:
  - Issue r1..r7.
  - Required: pending_count=7, issue_ready=0 for r1..r7 and 1 for r0.
  - Then wb r3 and issue r3 the following cycle.
  - Required: accepted, pending_count returns to 7.
- Reset mid-operation:
  - Issue r2 and r9, assert wb_valid for r2, and assert reset before the next edge.
  - Required: we_onehot stays 0, busy=0, pending_count=0, no wb_err.

Source files
------------

// File: rtl/reg_decode_scoreboard.sv
// Register-file write decoder with a pending-write scoreboard.
// Tracks in-flight destination writes, throttles issue to busy registers,
// flags RAW hazards on two source ports and produces a registered one-hot
// write enable for the register file.
module reg_decode_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_addr,
  output logic                issue_ready,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_addr,
  output logic [2**ADDR_W-1:0] we_onehot,
  output logic                wb_err,
  input  logic [ADDR_W-1:0]   rs_addr_a,
  input  logic [ADDR_W-1:0]   rs_addr_b,
  output logic                hazard_a,
  output logic                hazard_b,
  output logic [2**ADDR_W-1:0] busy,
  output logic [ADDR_W:0]     pending_count
);

  localparam int NREG = 2**ADDR_W;
  localparam int CW   = ADDR_W + 1;

  logic            issue_masked;
  logic            wb_masked;
  logic            rs_a_masked;
  logic            rs_b_masked;
  logic            fire;
  logic            inc;
  logic            dec;
  logic            err_next;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] busy_next;

  // Issue acceptance, hazard lookup and next scoreboard state.
  // The set vector is applied after the clear so a same-address issue wins.
  always_comb begin
    issue_masked = ZERO_REG && (issue_addr == '0);
    wb_masked    = ZERO_REG && (wb_addr == '0);
    rs_a_masked  = ZERO_REG && (rs_addr_a == '0);
    rs_b_masked  = ZERO_REG && (rs_addr_b == '0);

    issue_ready  = issue_masked || !busy[issue_addr];
    fire         = issue_valid && issue_ready;

    hazard_a     = !rs_a_masked && busy[rs_addr_a];
    hazard_b     = !rs_b_masked && busy[rs_addr_b];

    set_vec = '0;
    if (fire && !issue_masked) begin
      set_vec[issue_addr] = 1'b1;
    end

    clr_vec = '0;
    if (wb_valid && !wb_masked) begin
      clr_vec[wb_addr] = 1'b1;
    end

    busy_next = (busy & ~clr_vec) | set_vec;

    inc      = fire && !issue_masked;
    dec      = wb_valid && !wb_masked && busy[wb_addr];
    err_next = wb_valid && !wb_masked && !busy[wb_addr];
  end

  // Scoreboard state, count, write-enable decode and error pulse.
  // The clear vector doubles as the one-hot decode of the writeback address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy          <= '0;
      pending_count <= '0;
      we_onehot     <= '0;
      wb_err        <= 1'b0;
    end else begin
      busy          <= busy_next;
      pending_count <= pending_count + CW'(inc) - CW'(dec);
      we_onehot     <= clr_vec;
      wb_err        <= err_next;
    end
  end

endmodule
